sprite_palette_lut: RTL and testbench

SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

---
 rtl/palette_pkg.sv | 20 ++
 rtl/palette_ram.sv | 37 +++
 rtl/sprite_palette_lut.sv | 176 +++++++++++++++++
 tb/tb_sprite_palette_lut.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and default constants for the sprite palette lookup.
// rgb_t is sized for the default channel width.
package palette_pkg;

    localparam int unsigned IDX_W_DEF      = 8;
    localparam int unsigned CH_W_DEF       = 4;
    localparam int unsigned TRANSP_IDX_DEF = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CH_W_DEF-1:0] red;
        logic [CH_W_DEF-1:0] green;
        logic [CH_W_DEF-1:0] blue;
    } rgb_t;

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the new data.
module palette_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Sprite palette lookup: clears the palette after reset, then serves one
// pixel lookup per cycle. Optional PALETTE_FADE_EN adds a per-request fade.
module sprite_palette_lut
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned CH_W       = CH_W_DEF,
    parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_valid_i,
    input  logic [IDX_W-1:0]  pix_index_i,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
`ifdef PALETTE_FADE_EN
    input  logic [CH_W-1:0]   fade_i,
`endif
    output logic              init_busy,
    output logic              pix_valid_o,
    output logic [CH_W-1:0]   red_o,
    output logic [CH_W-1:0]   green_o,
    output logic [CH_W-1:0]   blue_o,
    output logic              transp_o
);

    localparam int unsigned DW = 3 * CH_W;
    localparam int unsigned PW = 2 * CH_W;
    localparam logic [IDX_W-1:0] CNT_LAST = '1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic             valid_s1_q, valid_s1_d;
    logic [IDX_W-1:0] idx_s1_q, idx_s1_d;
    logic             init_s1_q, init_s1_d;
    logic             valid_rd_q, valid_rd_d;
    logic             transp_rd_q, transp_rd_d;
    logic             init_rd_q, init_rd_d;
    logic             valid_o_q, valid_o_d;
    logic [DW-1:0]    rgb_q, rgb_d;
    logic             transp_q, transp_d;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [DW-1:0]    ram_wdata;
    logic [DW-1:0]    ram_rdata;
    logic [DW-1:0]    colour;

`ifdef PALETTE_FADE_EN
    logic [CH_W-1:0]  fade_s1_q, fade_s1_d;
    logic [CH_W-1:0]  fade_rd_q, fade_rd_d;

    function automatic logic [CH_W-1:0] fade_scale(input logic [CH_W-1:0] c,
                                                   input logic [CH_W-1:0] f);
        logic [PW-1:0] prod;
        prod = PW'(c) * (PW'(f) + PW'(1));
        return CH_W'(prod >> CH_W);
    endfunction
`endif

    // Clear sweep owns the write port in INIT; host writes are dropped there.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = '0;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  ram_we = wr_en;
            default: state_d = ST_INIT;
        endcase
        if (Reset) begin
            ram_we = 1'b0;
        end
        busy_d = (state_d == ST_INIT);
    end

    palette_ram #(
        .AW (IDX_W),
        .DW (DW)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (idx_s1_q),
        .rdata (ram_rdata)
    );

    // Request capture, RAM read stage, then registered colour output.
    always_comb begin
        valid_s1_d  = pix_valid_i;
        idx_s1_d    = pix_index_i;
        init_s1_d   = (state_q == ST_INIT);
        valid_rd_d  = valid_s1_q;
        transp_rd_d = (idx_s1_q == IDX_W'(TRANSP_IDX));
        init_rd_d   = init_s1_q;
`ifdef PALETTE_FADE_EN
        fade_s1_d   = fade_i;
        fade_rd_d   = fade_s1_q;
        colour      = {fade_scale(ram_rdata[DW-1 -: CH_W], fade_rd_q),
                       fade_scale(ram_rdata[PW-1 -: CH_W], fade_rd_q),
                       fade_scale(ram_rdata[CH_W-1:0], fade_rd_q)};
`else
        colour      = ram_rdata;
`endif
        if (init_rd_q) begin
            colour = '0;
        end
        valid_o_d = valid_rd_q;
        rgb_d     = rgb_q;
        transp_d  = transp_q;
        if (valid_rd_q) begin
            rgb_d    = colour;
            transp_d = transp_rd_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            valid_s1_q  <= 1'b0;
            idx_s1_q    <= '0;
            init_s1_q   <= 1'b0;
            valid_rd_q  <= 1'b0;
            transp_rd_q <= 1'b0;
            init_rd_q   <= 1'b0;
            valid_o_q   <= 1'b0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
`ifdef PALETTE_FADE_EN
            fade_s1_q   <= '0;
            fade_rd_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            valid_s1_q  <= valid_s1_d;
            idx_s1_q    <= idx_s1_d;
            init_s1_q   <= init_s1_d;
            valid_rd_q  <= valid_rd_d;
            transp_rd_q <= transp_rd_d;
            init_rd_q   <= init_rd_d;
            valid_o_q   <= valid_o_d;
            rgb_q       <= rgb_d;
            transp_q    <= transp_d;
`ifdef PALETTE_FADE_EN
            fade_s1_q   <= fade_s1_d;
            fade_rd_q   <= fade_rd_d;
`endif
        end
    end

    assign init_busy   = busy_q;
    assign pix_valid_o = valid_o_q;
    assign red_o       = rgb_q[DW-1 -: CH_W];
    assign green_o     = rgb_q[PW-1 -: CH_W];
    assign blue_o      = rgb_q[CH_W-1:0];
    assign transp_o    = transp_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Self-checking bench for sprite_palette_lut (default parameters).
// Fade checks are compiled in when PALETTE_FADE_EN is defined.
module tb_sprite_palette_lut;
    import palette_pkg::*;

    localparam int unsigned DEPTH = 256;

    logic        Clk;
    logic        Reset;
    logic        pix_valid_i;
    logic [7:0]  pix_index_i;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
`ifdef PALETTE_FADE_EN
    logic [3:0]  fade_i;
`endif
    logic        init_busy;
    logic        pix_valid_o;
    logic [3:0]  red_o, green_o, blue_o;
    logic        transp_o;

    sprite_palette_lut dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_valid_i (pix_valid_i),
        .pix_index_i (pix_index_i),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef PALETTE_FADE_EN
        .fade_i      (fade_i),
`endif
        .init_busy   (init_busy),
        .pix_valid_o (pix_valid_o),
        .red_o       (red_o),
        .green_o     (green_o),
        .blue_o      (blue_o),
        .transp_o    (transp_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: palette contents, remaining clear cycles, two request slots.
    typedef struct {
        bit         v;
        logic [7:0] idx;
        bit         init;
        logic [3:0] fade;
    } req_t;

    logic [11:0] m_mem [DEPTH];
    int          m_init_left;
    req_t        sa;
    bit          sb_v;
    logic [11:0] sb_rgb;
    bit          sb_tr;
    bit          o_v;
    logic [11:0] o_rgb;
    bit          o_tr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          same;
        bit          we;
        logic [7:0]  wa;
        logic [11:0] wd;
        logic [7:0]  idx;
        logic [11:0] exp_rgb;
        bit          exp_tr;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] f);
        return 4'((int'(c) * (int'(f) + 1)) / 16);
    endfunction

    function automatic logic [11:0] fade_rgb(input logic [11:0] c, input logic [3:0] f);
        rgb_t x, y;
        x = c;
        y.red   = fade_ch(x.red, f);
        y.green = fade_ch(x.green, f);
        y.blue  = fade_ch(x.blue, f);
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] idx, input bit we,
                        input logic [7:0] wa, input logic [11:0] wd, input logic [3:0] f);
        bit         busy;
        logic [3:0] fe;
        fe = 4'hF;
`ifdef PALETTE_FADE_EN
        fe = f;
        fade_i = f;
`endif
        Reset = rst; pix_valid_i = v; pix_index_i = idx;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge Clk);
        if (rst) begin
            m_init_left = DEPTH;
            sa = '{1'b0, 8'h00, 1'b0, 4'h0};
            sb_v = 1'b0;
            o_v = 1'b0; o_rgb = '0; o_tr = 1'b0;
        end else begin
            busy = (m_init_left > 0);
            if (!busy && we) m_mem[wa] = wd;
            o_v = sb_v;
            if (sb_v) begin
                o_rgb = sb_rgb;
                o_tr  = sb_tr;
            end
            sb_v   = sa.v;
            sb_rgb = sa.init ? 12'h000 : fade_rgb(m_mem[sa.idx], sa.fade);
            sb_tr  = (sa.idx == 8'h00);
            sa = '{v, idx, busy, fe};
            if (busy) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    foreach (m_mem[i]) m_mem[i] = 12'h000;
                end
            end
        end
        #1;
        chk("valid_o", 32'(pix_valid_o), 32'(o_v));
        chk("init_busy", 32'(init_busy), 32'(m_init_left > 0));
        chk("rgb", 32'({red_o, green_o, blue_o}), 32'(o_rgb));
        chk("transp", 32'(transp_o), 32'(o_tr));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 4'hF);
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (init_busy && n < 400) begin
            idle();
            n++;
        end
        chk(name, 32'(init_busy), 32'(0));
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h05;
            3: return 8'h21;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int cnt;
        tbl[0] = '{1'b0, 1'b0, 8'h00, 12'h000, 8'h37, 12'h000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h05, 12'h562, 8'h05, 12'h562, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h21, 12'hDCD, 8'h21, 12'hDCD, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 12'h793, 8'h00, 12'h793, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 12'h000, 8'h01, 12'h000, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h05, 12'hABC, 8'h05, 12'hABC, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 12'h000, 8'h21, 12'hDCD, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'h22, 12'h123, 8'h21, 12'hDCD, 1'b0};
        foreach (m_mem[i]) m_mem[i] = 12'h000;

        // Reset held three cycles, then the clear sweep with random traffic.
        repeat (3) step(1'b1, 1'b1, 8'h37, 1'b1, 8'h10, 12'hFFF, 4'hF);
        cnt = 0;
        while (init_busy && cnt < 400) begin
            step(1'b0, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
                 pick_addr(), 12'($urandom), 4'($urandom));
            cnt++;
        end
        chk("init_len", 32'(cnt), 32'(256));
        repeat (3) idle();

        // Directed lookups: request at edge N, result visible after edge N+2.
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].same) begin
                step(1'b0, 1'b1, tbl[i].idx, tbl[i].we, tbl[i].wa, tbl[i].wd, 4'hF);
            end else begin
                step(1'b0, 1'b0, 8'h00, tbl[i].we, tbl[i].wa, tbl[i].wd, 4'hF);
                step(1'b0, 1'b1, tbl[i].idx, 1'b0, 8'h00, 12'h000, 4'hF);
            end
            idle();
            chk($sformatf("tbl%0d_early", i), 32'(pix_valid_o), 32'(0));
            idle();
            chk($sformatf("tbl%0d_valid", i), 32'(pix_valid_o), 32'(1));
            chk($sformatf("tbl%0d_rgb", i), 32'({red_o, green_o, blue_o}), 32'(tbl[i].exp_rgb));
            chk($sformatf("tbl%0d_transp", i), 32'(transp_o), 32'(tbl[i].exp_tr));
        end

        // Reset pulse in the middle of a continuous request stream.
        repeat (5) step(1'b0, 1'b1, pick_addr(), 1'b0, 8'h00, 12'h000, 4'hF);
        step(1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 12'h000, 4'hF);
        chk("rst_valid0", 32'(pix_valid_o), 32'(0));
        chk("rst_busy", 32'(init_busy), 32'(1));
        step(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 12'h000, 4'hF);
        chk("rst_valid1", 32'(pix_valid_o), 32'(0));
        step(1'b0, 1'b1, 8'h05, 1'b1, 8'h10, 12'hFFF, 4'hF);
        wait_run("rst_init_done");
        step(1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 12'h000, 4'hF);
        idle();
        idle();
        chk("drop_valid", 32'(pix_valid_o), 32'(1));
        chk("drop_rgb", 32'({red_o, green_o, blue_o}), 32'(12'h000));

        // Random traffic with occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0), pick_addr(),
                 1'($urandom_range(0, 2) == 0), pick_addr(), 12'($urandom), 4'($urandom));
        end
        wait_run("rand_init_done");

`ifdef PALETTE_FADE_EN
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 12'h8A4, 4'hF);
        step(1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 12'h000, 4'h7);
        idle();
        idle();
        chk("fade7_rgb", 32'({red_o, green_o, blue_o}), 32'(12'h452));
        step(1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 12'h000, 4'hF);
        idle();
        idle();
        chk("fadeF_rgb", 32'({red_o, green_o, blue_o}), 32'(12'h8A4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
